// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with exact fill level, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and optional first-word-fall-through reads.
module sync_fifo_lvl #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = (1 << ASIZE) - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic             winc_i,
    input  logic             rinc_i,
    input  logic             clr_err_i,
    output logic [DSIZE-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             wfull_o,
    output logic             rempty_o,
    output logic             walmost_full_o,
    output logic             ralmost_empty_o,
    output logic [ASIZE:0]   level_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_L    = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_L    = (ASIZE+1)'(AE_LEVEL);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic [ASIZE-1:0] raddr_q, raddr_d;
    logic [ASIZE:0]   level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wa, ra;

    // Status flags decode the registered level only, so they never glitch.
    assign wfull_o         = (level_q == DEPTH_L);
    assign rempty_o        = (level_q == '0);
    assign walmost_full_o  = (level_q >= AF_L);
    assign ralmost_empty_o = (level_q <= AE_L);
    assign level_o         = level_q;
    assign overflow_o      = overflow_q;
    assign underflow_o     = underflow_q;

    // Accepts use the pre-edge flags: a simultaneous pop never frees a slot for a
    // write into a full FIFO, and a simultaneous push never feeds a read from empty.
    assign wa = winc_i & ~wfull_o;
    assign ra = rinc_i & ~rempty_o;

    always_comb begin
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        level_d     = level_q;
        overflow_d  = overflow_q & ~clr_err_i;
        underflow_d = underflow_q & ~clr_err_i;
        if (wa) waddr_d = waddr_q + 1'b1;
        if (ra) raddr_d = raddr_q + 1'b1;
        unique case ({wa, ra})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // A new error event wins over a coincident clear.
        if (winc_i & wfull_o)  overflow_d  = 1'b1;
        if (rinc_i & rempty_o) underflow_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            waddr_q     <= '0;
            raddr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wa) mem_q[waddr_q] <= wdata_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata_o  = mem_q[raddr_q];
            assign rvalid_o = ~rempty_o;
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= ra;
                    if (ra) rdata_q <= mem_q[raddr_q];
                end
            end

            assign rdata_o  = rdata_q;
            assign rvalid_o = rvalid_q;
        end
    endgenerate

endmodule

// File: doc/sync_fifo_lvl.md
Name: sync_fifo_lvl

Overview:
Single-clock successor to the dual-clock fifo1. It buffers DSIZE-bit words in a 2^ASIZE-deep memory and adds the following:
- an exact fill level;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

It is used where producer and consumer share one clock, so no gray-code pointer synchronisers are needed.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 4, address width; DEPTH = 2^ASIZE entries
AF_LEVEL, 2^ASIZE-2, walmost_full asserts when level >= AF_LEVEL (legal range 1..DEPTH)
AE_LEVEL, 2, ralmost_empty asserts when level <= AE_LEVEL (legal range 0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible on rdata without a pop

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
wdata  input  DSIZE  write data
winc  input  1  write request
rinc  input  1  read request (pop)
clr_err  input  1  synchronous clear of overflow/underflow
rdata  output  DSIZE  read data
rvalid  output  1  rdata qualifier
wfull  output  1  level == DEPTH
rempty  output  1  level == 0
walmost_full  output  1  level >= AF_LEVEL
ralmost_empty  output  1  level <= AE_LEVEL
level  output  ASIZE+1  current occupancy 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- State: waddr and raddr (each ASIZE bits, wrap naturally from DEPTH-1 to 0); level counter (ASIZE+1 bits); memory array with no reset.
- Reset (async assert, sync release) gives: waddr = raddr = 0, level = 0, rempty = 1, wfull = 0, walmost_full = (AF_LEVEL == 0 ? 1 : 0), ralmost_empty = 1, overflow = underflow = 0, rvalid = 0, rdata = 0 (when FWFT = 0).
- Write accept: wa = winc & !wfull. On accept, the word is written to mem[waddr] and waddr increments.
- Read accept: ra = rinc & !rempty. On accept, raddr increments.
- Flags are evaluated on the pre-edge level only:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Level update per edge:
  - +1 if wa & !ra
  - -1 if ra & !wa
  - unchanged otherwise, including when both are accepted simultaneously.
- All status outputs are combinational decodes of the registered level, so they are glitch-free and valid one cycle after the causing edge.
- FWFT = 0:
  - On an accepted read, rdata <= mem[raddr] and rvalid <= 1 on the same edge. Data is visible the cycle after rinc.
  - If the read is not accepted, rvalid <= 0 and rdata holds its last value.
- FWFT = 1:
  - rdata = mem[raddr] combinationally; rvalid = !rempty.
  - rinc with rvalid pops the word, and the next word appears in the following cycle.
  - A word written into an empty FIFO appears on rdata one cycle after the write edge.
- Error flags:
  - overflow <= 1 on any edge with winc & wfull; underflow <= 1 on any edge with rinc & rempty.
  - Both are cleared only by reset or clr_err. If clr_err coincides with a new error event in the same cycle, the flag is set.
- Rejected operations never modify memory, pointers or level.
- Reset asserted mid-stream discards all contents immediately. Memory contents are not cleared but become unreachable.

Test Plan:
- Reset then idle -> rempty=1, wfull=0, level=0, ralmost_empty=1, overflow=underflow=0, rvalid=0.
- DSIZE=8, ASIZE=4, FWFT=0: write 0x00..0x0F on 16 cycles -> level reaches 16, wfull=1, walmost_full=1 from level 14. Then read 16 words -> rdata 0x00..0x0F in order, each with rvalid one cycle after rinc, and rempty=1 at the end.
- Full FIFO, winc=1 and rinc=1 on the same cycle -> read accepted, write rejected, level 16->15, overflow=1. Assert clr_err -> overflow=0.
- Empty FIFO, winc=1 (0xA5) and rinc=1 on the same cycle -> write accepted, read rejected, level=1, underflow=1, rvalid=0.
- Steady state at level 8 with simultaneous winc/rinc for 40 cycles (pointer wrap-around) -> level stays 8, data order preserved across the wrap, no error flags.
- FWFT=1: write 0x3C into the empty FIFO -> next cycle rdata=0x3C and rvalid=1 with no rinc. Pop -> rvalid=0 and rempty=1 the following cycle.
